// File: rtl/serial_compare_ctrl_pkg.sv
// serial_compare_ctrl_pkg
// Shared constants and types for the serial compare controller.
//   WIDTH_DEF : default operand width in bits
//   state_t   : controller FSM state encoding (IDLE, COMPARE, DONE)
package serial_compare_ctrl_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    COMPARE = 2'b01,
    DONE    = 2'b10
  } state_t;

endpackage

// File: rtl/serial_compare_ctrl_one_bit_comparator.sv
// one_bit_comparator
// Single-bit magnitude comparator slice used by the serial controller.
//   a  : input  bit of operand A
//   b  : input  bit of operand B
//   eq : output high when a == b
//   lt : output high when a < b (a=0, b=1)
module one_bit_comparator (
  input  logic a,
  input  logic b,
  output logic eq,
  output logic lt
);

  // Pure combinational compare of one bit pair
  always_comb begin
    eq = ~(a ^ b);
    lt = ~a & b;
  end

endmodule

// File: rtl/serial_compare_ctrl.sv
// serial_compare_ctrl
// Compares two unsigned operands one bit per cycle, MSB (index 0) first,
// stopping at the first differing bit.
//   clk   : input  clock, rising edge
//   rst   : input  asynchronous active-high reset
//   start : input  compare request, sampled only in IDLE
//   aa    : input  operand A [0:WIDTH-1], bit 0 is the MSB
//   bb    : input  operand B [0:WIDTH-1], bit 0 is the MSB
//   busy  : output high in COMPARE and DONE
//   done  : output one-cycle pulse when ee/ll carry a fresh result
//   ee    : output registered A == B
//   ll    : output registered A <  B (unsigned)
module serial_compare_ctrl
  import serial_compare_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [0:WIDTH-1] aa,
  input  logic [0:WIDTH-1] bb,
  output logic             busy,
  output logic             done,
  output logic             ee,
  output logic             ll
);

  localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(WIDTH - 1);
  localparam logic [IDXW-1:0] IDX_ZERO = IDXW'(0);
  localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);

  state_t           r_state;
  logic [IDXW-1:0]  r_idx;
  logic [0:WIDTH-1] r_a;
  logic [0:WIDTH-1] r_b;
  logic             r_busy;
  logic             r_done;
  logic             r_ee;
  logic             r_ll;

  state_t           w_state_nxt;
  logic [IDXW-1:0]  w_idx_nxt;
  logic [0:WIDTH-1] w_a_nxt;
  logic [0:WIDTH-1] w_b_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic             w_ee_nxt;
  logic             w_ll_nxt;

  logic             w_a_bit;
  logic             w_b_bit;
  logic             w_eq;
  logic             w_lt;

  // Select the captured bit pair under examination this cycle
  always_comb begin
    w_a_bit = r_a[r_idx];
    w_b_bit = r_b[r_idx];
  end

  one_bit_comparator u_slice (
    .a  (w_a_bit),
    .b  (w_b_bit),
    .eq (w_eq),
    .lt (w_lt)
  );

  // Next-state and next-output decode for the compare FSM
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_ee_nxt    = r_ee;
    w_ll_nxt    = r_ll;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_a_nxt     = aa;
          w_b_nxt     = bb;
          w_idx_nxt   = IDX_ZERO;
          w_busy_nxt  = 1'b1;
          w_state_nxt = COMPARE;
        end else begin
          w_busy_nxt  = 1'b0;
        end
      end
      COMPARE: begin
        if (!w_eq) begin
          // First differing bit decides the order; A is smaller when its bit is 0
          w_ee_nxt    = 1'b0;
          w_ll_nxt    = w_lt;
          w_done_nxt  = 1'b1;
          w_state_nxt = DONE;
        end else if (r_idx == IDX_LAST) begin
          w_ee_nxt    = 1'b1;
          w_ll_nxt    = 1'b0;
          w_done_nxt  = 1'b1;
          w_state_nxt = DONE;
        end else begin
          w_idx_nxt   = r_idx + IDX_ONE;
        end
      end
      DONE: begin
        // start is deliberately not looked at here
        w_busy_nxt  = 1'b0;
        w_state_nxt = IDLE;
      end
      default: begin
        w_busy_nxt  = 1'b0;
        w_idx_nxt   = IDX_ZERO;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= IDX_ZERO;
      r_a     <= {WIDTH{1'b0}};
      r_b     <= {WIDTH{1'b0}};
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ee    <= 1'b0;
      r_ll    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_ee    <= w_ee_nxt;
      r_ll    <= w_ll_nxt;
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign ee   = r_ee;
  assign ll   = r_ll;

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// tb_serial_compare_ctrl
// Scoreboard bench: stimulus pushes the expected result and completion cycle,
// a forked monitor pops and compares on every done pulse.
module tb_serial_compare_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [0:W-1] aa;
  logic [0:W-1] bb;
  logic         busy;
  logic         done;
  logic         ee;
  logic         ll;

  typedef struct {
    logic ee;
    logic ll;
    int   due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  logic held_ee = 1'b0;
  logic held_ll = 1'b0;

  serial_compare_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .aa    (aa),
    .bb    (bb),
    .busy  (busy),
    .done  (done),
    .ee    (ee),
    .ll    (ll)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Reference: unsigned magnitude compare; latency = first differing MSB-first index + 1
  task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b, input int accept_edge);
    exp_t e;
    int   lat;
    int   msb;
    logic [W-1:0] x;
    x = a ^ b;
    if (a == b) begin
      lat = W;
    end else begin
      msb = 0;
      for (int i = 0; i < W; i++) if (x[i]) msb = i;
      lat = (W - 1 - msb) + 1;
    end
    e.ee  = (a == b);
    e.ll  = (a < b);
    e.due = accept_edge + lat;
    sb.push_back(e);
  endtask

  task automatic mon_step();
    exp_t e;
    if (rst) begin
      held_ee = 1'b0;
      held_ll = 1'b0;
    end else if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("ee", int'(ee), int'(e.ee));
        chk("ll", int'(ll), int'(e.ll));
        chk("done_cycle", cyc, e.due);
        chk("ee_ll_exclusive", int'(ee & ll), 0);
        held_ee = e.ee;
        held_ll = e.ll;
      end
    end else begin
      chk("hold_ee", int'(ee), int'(held_ee));
      chk("hold_ll", int'(ll), int'(held_ll));
      if (sb.size() > 0 && cyc > sb[0].due) begin
        chk("done_timeout", cyc, sb[0].due);
        void'(sb.pop_front());
      end
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 1, 0);
  endtask

  // Present one operand pair for a single-cycle start pulse
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    wait_idle();
    aa    = a;
    bb    = b;
    start = 1'b1;
    push_exp(a, b, cyc + 1);
    @(negedge clk);
    start = 1'b0;
  endtask

  logic [W-1:0] ra;
  logic [W-1:0] rb;

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    aa    = '0;
    bb    = '0;
    fork
      forever begin
        @(negedge clk);
        mon_step();
      end
    join_none

    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_ee", int'(ee), 0);
    chk("rst_ll", int'(ll), 0);
    #1 rst = 1'b0;

    // Directed corner cases
    issue(8'h00, 8'h00);
    issue(8'h00, 8'h80);
    issue(8'hA0, 8'h80);
    issue(8'hFF, 8'hFE);
    issue(8'h7F, 8'hFF);

    // Operand changes and start pulse during COMPARE must be ignored
    issue(8'h01, 8'h01);
    @(negedge clk);
    bb    = 8'hFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    // Held start: three back-to-back compares
    for (int k = 0; k < 3; k++) begin
      wait_idle();
      ra    = 8'($urandom);
      rb    = (k == 1) ? ra : 8'($urandom);
      aa    = ra;
      bb    = rb;
      start = 1'b1;
      push_exp(ra, rb, cyc + 1);
      @(negedge clk);
    end
    start = 1'b0;

    // Reset on the 4th COMPARE cycle aborts with no done pulse
    ra = 8'($urandom);
    issue(ra, ra);
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_ee", int'(ee), 0);
    chk("abort_ll", int'(ll), 0);
    sb.delete();
    @(negedge clk);
    #1 rst = 1'b0;
    issue(8'h80, 8'h00);

    // Randomized compares, biased toward shared prefixes
    for (int n = 0; n < 40; n++) begin
      ra = 8'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = ra ^ (8'h01 << $urandom_range(0, 7));
        2:       rb = ra ^ (8'h01 << $urandom_range(0, 2));
        default: rb = 8'($urandom);
      endcase
      issue(ra, rb);
    end

    begin
      int n;
      n = 0;
      while (sb.size() > 0 && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (sb.size() > 0) chk("drain", sb.size(), 0);
    end
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_compare_ctrl.md
SERIAL_COMPARE_CTRL -- requirements
Module: serial_compare_ctrl

Interface
REQ-001 Parameter: WIDTH, 8, operand width in bits; the index range is [0:WIDTH-1] and bit 0 is the MSB.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: start  input  1  request a compare; sampled only in IDLE.
REQ-005 Port: aa  input  WIDTH  operand A; captured on an accepted start.
REQ-006 Port: bb  input  WIDTH  operand B; captured on an accepted start.
REQ-007 Port: busy  output  1  high in COMPARE and DONE.
REQ-008 Port: done  output  1  one-cycle pulse marking a valid result.
REQ-009 Port: ee  output  1  registered result, high when A == B.
REQ-010 Port: ll  output  1  registered result, high when A < B (unsigned).

Function
REQ-011 FSM states SHALL be IDLE, COMPARE and DONE.
REQ-012 In IDLE with start=1, the block SHALL capture aa and bb into internal registers, clear the bit index to 0 and move to COMPARE.
REQ-013 In COMPARE, each cycle SHALL examine captured bit [idx] of A and B through one 1-bit comparator slice, MSB first.
REQ-014 If the bits differ, the block SHALL register ee=0 and ll=(A[idx]==0) and go to DONE on that edge (early termination).
REQ-015 If the bits are equal and idx==WIDTH-1, the block SHALL register ee=1 and ll=0 and go to DONE.
REQ-016 Otherwise the block SHALL increment idx and stay in COMPARE.
REQ-017 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-018 Latency: done SHALL be high d+1 edges after the start-sampling edge, where d is the first differing index; if A == B, done SHALL be high WIDTH edges after that edge.
REQ-019 ee and ll SHALL change only on the edge entering DONE and hold their values until the next such edge or reset.
REQ-020 start SHALL be ignored while busy=1, including the DONE cycle; a continuously held start SHALL give back-to-back compares separated by exactly one IDLE cycle.
REQ-021 Changes on aa or bb after capture SHALL have no effect on the compare in progress.
REQ-022 ee and ll SHALL never both be 1.

Reset
REQ-023 On rst=1, the block SHALL immediately (asynchronously) set state=IDLE, idx=0, busy=0, done=0, ee=0, ll=0 and clear the operand registers.
REQ-024 A reset during COMPARE or DONE SHALL abort the operation with no done pulse.
REQ-025 The first start after rst deasserts SHALL be accepted normally.

Structure
REQ-026 A shared package SHALL hold the WIDTH default constant and the state enum typedef (IDLE, COMPARE, DONE).
REQ-027 The 1-bit comparator slice SHALL be a separate combinational sub-module, one_bit_comparator (inputs a, b; outputs eq, lt), instantiated once.
REQ-028 The controller SHALL contain no WIDTH-wide combinational magnitude comparator.

Verification (hex values are written MSB = bit 0)
REQ-029 Equal operands: aa=8'h00, bb=8'h00, start pulse -> done 8 edges after start, ee=1, ll=0.
REQ-030 Difference at MSB: aa=8'h00, bb=8'h80 -> done 1 edge after start, ee=0, ll=1.
REQ-031 Difference at bit 2: aa=8'hA0, bb=8'h80 -> done 3 edges after start, ee=0, ll=0.
REQ-032 Ignored inputs: with aa=8'h01, bb=8'h01 accepted, change bb to 8'hFF and pulse start during COMPARE -> one result only, ee=1, ll=0, done 8 edges after the first start.
REQ-033 Reset mid-operation: assert rst on the 4th COMPARE cycle -> busy, done, ee and ll go to 0 before the next edge; no done pulse; a following start with aa=8'h80, bb=8'h00 -> ee=0, ll=0 after 1 edge.
REQ-034 Held start: keep start high for three compares -> done pulses spaced by latency+2 cycles, each with correct ee/ll.
